// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and helpers for the seven-segment scan controller.
// lz_mask is only referenced when LEADING_ZERO_BLANK_EN is defined.
package seg7_pkg;
  localparam int MAX_DIGITS = 8;
  typedef logic [3:0] nibble_t;
  typedef logic [2:0] digit_idx_t;
  typedef logic [31:0] disp_word_t;
  typedef enum logic {IDLE, PENDING} scan_state_e;
  // Bit k set when nibbles k..n-1 are all zero; digit 0 always stays lit
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input disp_word_t w, input int n);
    logic z;
    lz_mask = '1;
    z = 1'b1;
    for (int k = MAX_DIGITS - 1; k > 0; k--) begin
      if (k < n) z = z & (w[4*k +: 4] == 4'h0);
      lz_mask[k] = z;
    end
    lz_mask[0] = 1'b0;
  endfunction
endpackage

// File: rtl/seg7_refresh_div.sv
// seg7_refresh_div: free-running divider, digit_tick_o high on the last cycle of each digit period.
module seg7_refresh_div #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic digit_tick_o
);
  localparam int W = $clog2(REFRESH_DIV);
  logic [W-1:0] div_q;
  assign digit_tick_o = div_q == W'(REFRESH_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_q <= '0;
    else div_q <= digit_tick_o ? '0 : div_q + 1'b1;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit scan controller with tear-free frame-boundary display updates.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  digit_en,
  output logic [3:0]  num,
  output logic [2:0]  sel,
  output logic        blank,
  output logic        frame_tick
);
  scan_state_e state_q;
  digit_idx_t  idx_q, sel_q;
  disp_word_t  disp_q, pend_q;
  nibble_t     num_q;
  logic        blank_q, ft_q, wrap_q, digit_tick, wrap, lz_bit;
  seg7_refresh_div #(.REFRESH_DIV(REFRESH_DIV)) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit_tick_o (digit_tick)
  );
  assign wrap       = digit_tick && idx_q == digit_idx_t'(NUM_DIGITS - 1);
  assign load_ready = rst_n && state_q == IDLE;
  assign num        = num_q;
  assign sel        = sel_q;
  assign blank      = blank_q;
  assign frame_tick = ft_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic [MAX_DIGITS-1:0] lz_q;
  assign lz_bit = lz_q[idx_q];
  // Mask tracks disp_q, so it only changes on commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lz_q <= lz_mask('0, NUM_DIGITS);
    else if (state_q == PENDING && wrap) lz_q <= lz_mask(pend_q, NUM_DIGITS);
`else
  assign lz_bit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      wrap_q  <= 1'b0;
      ft_q    <= 1'b0;
      sel_q   <= '0;
      num_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      idx_q   <= wrap ? '0 : idx_q + digit_idx_t'(digit_tick);
      wrap_q  <= wrap;
      ft_q    <= wrap_q;
      sel_q   <= idx_q;
      num_q   <= disp_q[{idx_q, 2'b00} +: 4];
      blank_q <= ~digit_en[idx_q] | lz_bit;
      if (state_q == IDLE && load_valid) begin
        pend_q  <= load_data;
        state_q <= PENDING;
      end else if (state_q == PENDING && wrap) begin
        disp_q  <= pend_q;
        state_q <= IDLE;
      end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: time-based reference model plus table vectors for seg7_scan_ctrl.
module tb_seg7_scan_ctrl;
  localparam int R = 4;
  localparam int N = 8;
  logic clk, rst_n, load_valid, load_ready, blank, frame_tick;
  logic [31:0] load_data;
  logic [7:0]  digit_en;
  logic [3:0]  num, num1;
  logic [2:0]  sel, sel1;
  logic        lv1, rdy1, blank1, ft1;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  seg7_scan_ctrl #(.REFRESH_DIV(R), .NUM_DIGITS(N)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .digit_en(digit_en), .num(num), .sel(sel),
    .blank(blank), .frame_tick(frame_tick));

  seg7_scan_ctrl #(.REFRESH_DIV(R), .NUM_DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(rdy1),
    .load_data(load_data), .digit_en(digit_en), .num(num1), .sel(sel1),
    .blank(blank1), .frame_tick(ft1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: after e clean edges the scan index is (e/R)%N; a wrap happens on
  // every edge number that is a multiple of R*N; outputs show pre-edge state.
  int e;
  logic [31:0] m_disp, m_pend;
  bit m_pv;
  logic [3:0] x_num;
  logic [2:0] x_sel;
  logic x_blank, x_ft;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e = 0; m_disp = 0; m_pend = 0; m_pv = 0;
      x_num = 0; x_sel = 0; x_blank = 1; x_ft = 0;
    end else begin
      x_sel   = 3'((e / R) % N);
      x_num   = m_disp[4*x_sel +: 4];
      x_blank = ~digit_en[x_sel];
`ifdef LEADING_ZERO_BLANK_EN
      if (x_sel != 0 && (m_disp >> (4 * x_sel)) == 0) x_blank = 1;
`endif
      x_ft = e > 0 && e % (R * N) == 0;
      if ((e + 1) % (R * N) == 0 && m_pv) begin
        m_disp = m_pend;
        m_pv = 0;
      end else if (load_valid && !m_pv) begin
        m_pend = load_data;
        m_pv = 1;
      end
      e++;
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("num", num, x_num);
      chk("sel", sel, x_sel);
      chk("blank", blank, x_blank);
      chk("frame_tick", frame_tick, x_ft);
      chk("load_ready", load_ready, rst_n && !m_pv);
    end

  task automatic wait_ft(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 200);
    chk(nm, frame_tick, 1'b1);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, load_ready, 1'b1);
  endtask

  // Called at a negedge; holds valid until the handshake completes
  task automatic send(input logic [31:0] d);
    load_valid = 1;
    load_data  = d;
    wait_ready("send_ready_timeout");
    @(negedge clk);
    load_valid = 0;
  endtask

  task automatic check_frame(input string nm, input logic [31:0] w, input logic [7:0] m);
    for (int c = 0; c < R * N; c++) begin
      chk({nm, "_num"}, num, w[4*(c/R) +: 4]);
      chk({nm, "_blank"}, blank, m[c/R]);
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [7:0]  en;
    logic [7:0]  bl_plain;
    logic [7:0]  bl_lz;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] m;
    tbl[0] = '{32'h8765_4321, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{32'hAAAA_AAAA, 8'b0000_0101, 8'hFA, 8'hFA};
    tbl[2] = '{32'h0000_0305, 8'hFF, 8'h00, 8'hF8};
    tbl[3] = '{32'h0000_0000, 8'hFF, 8'h00, 8'hFE};
    tbl[4] = '{32'h5555_5555, 8'h0F, 8'hF0, 8'hF0};
    tbl[5] = '{32'h00F0_0000, 8'hFF, 8'h00, 8'hC0};
    rst_n = 0; load_valid = 0; load_data = 0; digit_en = 8'hFF; lv1 = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #2 rst_n = 1;
    // idle scan: frame period and sel alignment
    wait_ft("ft_first", n);
    wait_ft("ft_period_timeout", n);
    chk("ft_period", n, R * N);
    chk("ft_sel0", sel, 0);
    // mid-frame load
    repeat (9) @(negedge clk);
    load_valid = 1; load_data = 32'h8765_4321;
    @(negedge clk);
    load_valid = 0;
    chk("ready_drop", load_ready, 1'b0);
    chk("num_before_commit", num, x_num);
    wait_ready("commit_timeout");
    wait_ft("ft_after_commit", n);
    check_frame("mid_load", 32'h8765_4321, 8'h00);
    // back-to-back loads on consecutive frames
    send(32'hAAAA_AAAA);
    send(32'h5555_5555);
    chk("b2b_ft", frame_tick, 1'b1);
    chk("b2b_first", num, 4'hA);
    wait_ft("b2b_ft2", n);
    chk("b2b_second", num, 4'h5);
    // table vectors
    foreach (tbl[i]) begin
      digit_en = tbl[i].en;
      send(tbl[i].word);
      wait_ready("tbl_commit");
      wait_ft("tbl_ft", n);
`ifdef LEADING_ZERO_BLANK_EN
      m = tbl[i].bl_lz;
`else
      m = tbl[i].bl_plain;
`endif
      check_frame($sformatf("tbl%0d", i), tbl[i].word, m);
    end
    digit_en = 8'hFF;
    // reset while pending
    @(negedge clk);
    load_valid = 1; load_data = 32'h1234_5678;
    @(negedge clk);
    load_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_num", num, 0);
    chk("async_sel", sel, 0);
    chk("async_blank", blank, 1'b1);
    chk("async_ft", frame_tick, 1'b0);
    chk("async_ready", load_ready, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    #1 chk("post_rst_ready", load_ready, 1'b1);
    wait_ft("post_rst_ft", n);
    check_frame("post_rst", 32'h0, 8'h00);
    // single-digit instance wraps on every digit tick
    n = 0;
    while (!ft1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("n1_ft_first", ft1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ft1 && n < 50);
      chk("n1_ft_period", n, R);
      chk("n1_sel", sel1, 0);
    end
    // randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      load_valid = ($urandom % 4) == 0;
      load_data  = $urandom;
      if ($urandom % 16 == 0) digit_en = 8'($urandom);
    end
    @(negedge clk);
    load_valid = 0;
    repeat (R * N * 2) @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Upstream driver for the 8-digit seven-segment decoder/anode-select stage.
- Holds a 32-bit display value (8 hex nibbles) and time-multiplexes it. Each digit period it presents one nibble on num and that digit's index on sel.
- Display updates arrive over a valid/ready handshake and commit only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit period. Legal range is 2 or more.
- NUM_DIGITS, 8: digits scanned, indices 0..NUM_DIGITS-1. Legal range is 1..8.

Ports:
- clk  input  1: system clock, rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- load_valid  input  1: load_data is valid this cycle.
- load_ready  output  1: block can accept load_data this cycle.
- load_data  input  32: new display value. Nibble k = load_data[4k+3:4k] maps to digit k; digit 0 is least significant.
- digit_en  input  8: per-digit enable mask. It is sampled live, not latched.
- num  output  4: nibble for the current digit, to the decoder's num input.
- sel  output  3: current digit index, to the decoder's sel input.
- blank  output  1: high when the current digit must be dark.
- frame_tick  output  1: one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (async assert, sync-safe release):
  - div_cnt=0, idx=0, disp_reg=0, pend_reg=0, pend_flag=0.
  - Outputs: num=0, sel=0, blank=1, frame_tick=0, load_ready=0 while rst_n low.
  - Reset mid-frame or mid-pending discards the pending value.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
  - digit_tick is asserted on the cycle div_cnt==REFRESH_DIV-1.
- Scan:
  - On digit_tick, idx advances to idx+1. If idx==NUM_DIGITS-1, idx wraps to 0 instead (a wrap).
  - With NUM_DIGITS=1, every digit_tick is a wrap.
  - sel, num and blank are registered: they update on the cycle after idx changes. Latency is one cycle from idx to outputs.
  - num = disp_reg nibble[idx].
  - blank = ~digit_en[idx], plus the optional feature below.
  - frame_tick is a registered pulse, high for exactly one cycle, aligned with sel returning to 0.
- Load handshake:
  - load_ready = ~pend_flag (when out of reset).
  - Transfer happens when load_valid & load_ready. On transfer: pend_reg <= load_data, pend_flag <= 1.
  - load_data is don't-care when load_valid is low. Repeated holds of load_valid with load_ready low do not transfer.
- Commit:
  - On a wrap tick with pend_flag=1: disp_reg <= pend_reg, pend_flag <= 0.
  - The new value is therefore first visible on digit 0 of the next frame.
  - load_ready rises the cycle after commit.
  - A transfer cannot coincide with a commit, because ready is low while pending.
  - A transfer on the same cycle as a wrap tick (pend_flag was 0) is held until the following wrap.
- Width rules:
  - Unused digit indices (idx >= NUM_DIGITS) are never produced.
  - The upper nibbles of disp_reg are stored but never displayed.
  - div_cnt width is $clog2(REFRESH_DIV).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: a digit k>0 is also blanked when nibbles k..NUM_DIGITS-1 of disp_reg are all zero. Digit 0 is never blanked by this rule, so value 0 shows a single "0". The suppression mask is recomputed only on commit (registered), adding no scan latency.
- Undefined: the mask logic is absent; blank depends on digit_en only.

Decomposition:
- Package seg7_pkg contains:
  - MAX_DIGITS=8
  - typedef logic [3:0] nibble_t
  - typedef logic [2:0] digit_idx_t
  - typedef logic [31:0] disp_word_t
- Sub-module seg7_refresh_div, parameterised by REFRESH_DIV: outputs digit_tick. The top instantiates it once.
- The scan/handshake FSM stays in the top. Its states are IDLE (no pending value) and PENDING, with PENDING returning to IDLE on a wrap tick.

Test Plan (REFRESH_DIV=4, NUM_DIGITS=8 unless noted):
1. Reset then release, no loads:
   - sel steps 0,1..7,0 every 4 cycles.
   - num=0 throughout.
   - frame_tick pulses every 32 cycles, coincident with sel=0.
2. Load 32'h8765_4321 mid-frame:
   - load_ready drops the next cycle.
   - num stays 0 until the next wrap, then shows 1,2,..8 for sel 0..7.
   - load_ready rises one cycle after the commit.
3. Second load with load_valid held while pending:
   - No transfer until load_ready=1; exactly one transfer occurs.
   - Back-to-back loads 32'hAAAA_AAAA then 32'h5555_5555 appear on consecutive frames.
4. digit_en=8'b0000_0101:
   - blank=0 only when sel=0 or 2; num is still driven on all digits.
5. Assert rst_n low for 3 cycles during PENDING:
   - Outputs clear immediately, asynchronously.
   - After release, load_ready=1, disp_reg=0, and the pending value is never displayed.
6. With LEADING_ZERO_BLANK_EN, load 32'h0000_0305:
   - Digits 0..2 unblanked and digits 3..7 blanked.
   - Load 0: only digit 0 unblanked.
   - NUM_DIGITS=1 run: frame_tick every 4 cycles.
